// File: rtl/seq1010_pkg.sv
// Shared types and helpers for the 1010 scan sequencer.
// Controller and detector state encodings live here.
package seq1010_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    D_NONE,
    D_1,
    D_10,
    D_101
  } det_e;

  localparam logic [31:0] FIRST_NONE = '1;

  function automatic int lw_of(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq1010_if.sv
// Start/result bundle between a parallel producer and the scan sequencer.
// The producer uses master, the sequencer uses slave.
interface seq1010_if
  import seq1010_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  localparam int LW = lw_of(WIDTH);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] data_in;
  logic [LW-1:0]    len;
  logic             clear_hist;
  logic             abort;
  logic             ser_bit;
  logic             ser_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_count;
  logic [LW-1:0]    first_pos;

  modport master (
    output start_valid, data_in, len,
    output clear_hist, abort,
    input  start_ready, ser_bit, ser_en,
    input  busy, done, match_count, first_pos
  );

  modport slave (
    input  start_valid, data_in, len,
    input  clear_hist, abort,
    output start_ready, ser_bit, ser_en,
    output busy, done, match_count, first_pos
  );

endinterface

// File: rtl/seq1010_det.sv
// Overlapping bit-serial 1010 detector.
// Hit is registered: high the cycle after the completing bit.
module seq1010_det
  import seq1010_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_bit,
  output logic o_hit
);

  det_e r_s, w_s;
  logic r_hit, w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s   <= D_NONE;
      r_hit <= 1'b0;
    end else begin
      r_s   <= w_s;
      r_hit <= w_hit;
    end
  end

  always_comb begin
    w_s   = r_s;
    w_hit = 1'b0;
    if (i_clr) begin
      w_s = D_NONE;
    end else if (i_en) begin
      unique case (r_s)
        D_NONE: w_s = i_bit ? D_1   : D_NONE;
        D_1:    w_s = i_bit ? D_1   : D_10;
        D_10:   w_s = i_bit ? D_101 : D_NONE;
        D_101: begin
          // trailing "10" of a match seeds the next one
          w_s   = i_bit ? D_1 : D_10;
          w_hit = !i_bit;
        end
        default: w_s = D_NONE;
      endcase
    end
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/seq1010_scan_ctrl.sv
// Sequencer: accepts a word, shifts it MSB-first into the detector,
// then reports match count and first match offset.
module seq1010_scan_ctrl
  import seq1010_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
)
(
  input logic   clk,
  input logic   rst_n,
  seq1010_if.slave bus
);

  localparam int LW = lw_of(WIDTH);
  localparam logic [LW-1:0]    W_MAX = LW'(WIDTH);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  state_e r_state, w_next;

  logic [WIDTH-1:0] r_sh;
  logic [LW-1:0]    r_len;
  logic [LW-1:0]    r_k;
  logic [CNT_W-1:0] r_cnt;
  logic [LW-1:0]    r_first;

  logic          w_acc;
  logic          w_clr;
  logic          w_en;
  logic          w_bit;
  logic          w_hit;
  logic          w_last;
  logic          w_live;
  logic [LW-1:0] w_len;

  assign w_acc  = bus.start_valid && (r_state == ST_IDLE);
  assign w_clr  = w_acc && bus.clear_hist;
  assign w_len  = (bus.len > W_MAX) ? W_MAX : bus.len;
  assign w_en   = (r_state == ST_SHIFT);
  assign w_bit  = r_sh[WIDTH-1];
  assign w_last = (r_k == r_len - 1'b1);
  assign w_live = (r_state == ST_SHIFT) ||
                  (r_state == ST_DRAIN);

  seq1010_det u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_en  (w_en),
    .i_bit (w_bit),
    .o_hit (w_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start_valid)
          w_next = (w_len == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bus.abort)   w_next = ST_IDLE;
        else if (w_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: w_next = bus.abort ? ST_IDLE : ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // r_k runs one ahead of the hit it sees, so hit offset is r_k-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh    <= '0;
      r_len   <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_first <= FIRST_NONE[LW-1:0];
    end else if (w_acc) begin
      r_sh    <= bus.data_in << (W_MAX - w_len);
      r_len   <= w_len;
      r_k     <= '0;
      r_cnt   <= '0;
      r_first <= FIRST_NONE[LW-1:0];
    end else begin
      if (w_en) begin
        r_sh <= r_sh << 1;
        r_k  <= r_k + 1'b1;
      end
      if (w_live && w_hit) begin
        if (r_cnt == '0)   r_first <= r_k - 1'b1;
        if (r_cnt != C_MAX) r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.start_ready = (r_state == ST_IDLE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.ser_en      = w_en;
  assign bus.ser_bit     = w_en & w_bit;
  assign bus.match_count = r_cnt;
  assign bus.first_pos   = r_first;

endmodule

// File: tb/tb_seq1010_scan_ctrl.sv
// Bench for seq1010_scan_ctrl: vector table, corner sequences,
// random scans against a bit-history model.
module tb_seq1010_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq1010_if #(.WIDTH(16), .CNT_W(4)) bus1 ();
  seq1010_if #(.WIDTH(16), .CNT_W(2)) bus2 ();

  seq1010_scan_ctrl #(.WIDTH(16), .CNT_W(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  seq1010_scan_ctrl #(.WIDTH(16), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  typedef struct {
    logic [15:0] d;
    int          ln;
    logic        clr;
    int          cnt;
    int          first;
    int          cyc;
  } vec_t;

  vec_t tbl [7];
  int   n_chk = 0;
  int   n_fail = 0;
  logic hist [$];

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int clampl(input int ln);
    return (ln > 16) ? 16 : ln;
  endfunction

  function automatic int exp_bits(input logic [15:0] d, input int ln);
    int lc;
    logic [31:0] m;
    lc = clampl(ln);
    m = (lc == 0) ? 32'd0 : ((32'd1 << lc) - 32'd1);
    return int'({16'd0, d} & m);
  endfunction

  // Reference: keep the fed bit history, look at the last four bits.
  task automatic model(input logic [15:0] d, input int ln, input logic clr,
                       input int cmax, output int cnt, output int first);
    int lc;
    lc = clampl(ln);
    if (clr) hist.delete();
    cnt = 0;
    first = 31;
    for (int k = 0; k < lc; k++) begin
      hist.push_back(d[lc-1-k]);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4 && hist[0] == 1'b1 && hist[1] == 1'b0 &&
          hist[2] == 1'b1 && hist[3] == 1'b0) begin
        if (first == 31) first = k;
        if (cnt < cmax) cnt++;
      end
    end
  endtask

  task automatic scan1(input logic [15:0] d, input int ln, input logic clr,
                       output int cnt, output int first, output int cyc,
                       output int nbits, output int bits);
    logic [31:0] b;
    @(negedge clk);
    check("ready_idle", int'(bus1.start_ready), 1);
    bus1.data_in = d;
    bus1.len = 5'(ln);
    bus1.clear_hist = clr;
    bus1.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.start_valid = 1'b0;
    cyc = 1;
    nbits = 0;
    b = '0;
    while (!bus1.done && cyc < 40) begin
      if (bus1.ser_en) begin
        b = {b[30:0], bus1.ser_bit};
        nbits++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bits = int'(b);
    cnt = int'(bus1.match_count);
    first = int'(bus1.first_pos);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt, first, cyc, nb, bits, mc, mf, bad, seen;
    logic [15:0] d;
    int ln;
    logic clr;

    tbl[0] = '{16'h00AA, 8,  1'b1, 3, 3,  10};
    tbl[1] = '{16'h00F0, 8,  1'b1, 0, 31, 10};
    tbl[2] = '{16'h0002, 2,  1'b1, 0, 31, 4};
    tbl[3] = '{16'h0002, 2,  1'b0, 1, 1,  4};
    tbl[4] = '{16'h0002, 2,  1'b1, 0, 31, 4};
    tbl[5] = '{16'h5555, 0,  1'b1, 0, 31, 1};
    tbl[6] = '{16'hAAAA, 20, 1'b1, 7, 3,  18};

    bus1.start_valid = 0; bus1.data_in = 0; bus1.len = 0;
    bus1.clear_hist = 0; bus1.abort = 0;
    bus2.start_valid = 0; bus2.data_in = 0; bus2.len = 0;
    bus2.clear_hist = 0; bus2.abort = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(bus1.start_ready), 1);
    check("rst_busy", int'(bus1.busy), 0);
    check("rst_done", int'(bus1.done), 0);
    check("rst_ser_en", int'(bus1.ser_en), 0);
    check("rst_ser_bit", int'(bus1.ser_bit), 0);
    check("rst_count", int'(bus1.match_count), 0);
    check("rst_first", int'(bus1.first_pos), 31);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      scan1(tbl[i].d, tbl[i].ln, tbl[i].clr, cnt, first, cyc, nb, bits);
      check($sformatf("tbl%0d_count", i), cnt, tbl[i].cnt);
      check($sformatf("tbl%0d_first", i), first, tbl[i].first);
      check($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
      check($sformatf("tbl%0d_nbits", i), nb, clampl(tbl[i].ln));
      check($sformatf("tbl%0d_bits", i), bits,
            exp_bits(tbl[i].d, tbl[i].ln));
    end

    // saturation on the narrow-counter instance
    @(negedge clk);
    bus2.data_in = 16'hAAAA;
    bus2.len = 5'd16;
    bus2.clear_hist = 1'b1;
    bus2.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus2.start_valid = 1'b0;
    cyc = 1;
    while (!bus2.done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("sat_count", int'(bus2.match_count), 3);
    check("sat_first", int'(bus2.first_pos), 3);
    check("sat_cycles", cyc, 18);

    // start_valid held while busy must not disturb the scan
    @(negedge clk);
    bus1.data_in = 16'h00F0;
    bus1.len = 5'd8;
    bus1.clear_hist = 1'b1;
    bus1.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.data_in = 16'hAAAA;
    bus1.len = 5'd16;
    cyc = 1;
    bad = 0;
    while (!bus1.done && cyc < 40) begin
      if (bus1.start_ready) bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus1.start_valid = 1'b0;
    check("busy_ready_low", bad, 0);
    check("busy_count", int'(bus1.match_count), 0);
    check("busy_first", int'(bus1.first_pos), 31);
    check("busy_cycles", cyc, 10);
    @(posedge clk);
    #1;
    check("busy_back_idle", int'(bus1.start_ready), 1);

    // abort in SHIFT keeps partial results and never pulses done
    @(negedge clk);
    bus1.data_in = 16'hAAAA;
    bus1.len = 5'd16;
    bus1.clear_hist = 1'b1;
    bus1.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.start_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    bus1.abort = 1'b1;
    @(posedge clk);
    #1;
    bus1.abort = 1'b0;
    check("abort_ready", int'(bus1.start_ready), 1);
    check("abort_busy", int'(bus1.busy), 0);
    check("abort_count", int'(bus1.match_count), 1);
    check("abort_first", int'(bus1.first_pos), 3);
    seen = 0;
    repeat (14) begin
      if (bus1.done) seen++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", seen, 0);

    // asynchronous reset mid-SHIFT
    @(negedge clk);
    bus1.data_in = 16'hAAAA;
    bus1.len = 5'd16;
    bus1.clear_hist = 1'b1;
    bus1.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.start_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_count", int'(bus1.match_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", int'(bus1.start_ready), 1);
    check("arst_busy", int'(bus1.busy), 0);
    check("arst_ser_en", int'(bus1.ser_en), 0);
    check("arst_count", int'(bus1.match_count), 0);
    check("arst_first", int'(bus1.first_pos), 31);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();

    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      if ((i % 3) == 0) d = 16'hA5A5 ^ 16'($urandom_range(0, 15));
      ln = $urandom_range(0, 20);
      clr = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      model(d, ln, clr, 15, mc, mf);
      scan1(d, ln, clr, cnt, first, cyc, nb, bits);
      check($sformatf("rnd%0d_count", i), cnt, mc);
      check($sformatf("rnd%0d_first", i), first, mf);
      check($sformatf("rnd%0d_cycles", i), cyc,
            (clampl(ln) == 0) ? 1 : clampl(ln) + 2);
      check($sformatf("rnd%0d_nbits", i), nb, clampl(ln));
      check($sformatf("rnd%0d_bits", i), bits, exp_bits(d, ln));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
